// File: rtl/neo_fix_fetch.sv
// Fix-layer map fetch sequencer: reads one row of fix map words per line and
// replays each word on the P-bus with a doubled strobe for bankswitch snoopers.
module neo_fix_fetch #(
  parameter int          NUM_COLS   = 40,
  parameter logic [15:0] MAP_BASE   = 16'h7000,
  parameter logic [8:0]  FIRST_LINE = 9'd16
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        CLK_EN,
  input  logic        FIX_EN,
  input  logic        LINE_START,
  input  logic [8:0]  VCOUNT,
  output logic [15:0] VRAM_ADDR,
  output logic        VRAM_RD,
  input  logic        VRAM_ACK,
  input  logic [15:0] VRAM_DATA,
  output logic [10:0] ADDR,
  output logic [14:0] PBUS,
  output logic        PCK2B_EN,
  output logic [11:0] FIX_TILE,
  output logic [3:0]  FIX_PAL,
  output logic        TILE_VALID,
  output logic        BUSY
);

  typedef enum logic [2:0] {IDLE, SYNC_REQ, REQ, WAIT, STB1, STB2, NEXT} state_t;

  localparam logic [5:0] LAST_COL = 6'(NUM_COLS - 1);

  state_t      state;
  logic [5:0]  col;
  logic [4:0]  row;
  logic        is_sync;
  logic [15:0] data_q;
  logic [15:0] entry_addr, sync_addr;

  assign entry_addr = MAP_BASE | {5'd0, col, row};
  assign sync_addr  = MAP_BASE | 16'h07E2;

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      is_sync    <= 1'b0;
      data_q     <= '0;
      VRAM_ADDR  <= '0;
      VRAM_RD    <= 1'b0;
      ADDR       <= '0;
      PBUS       <= '0;
      PCK2B_EN   <= 1'b0;
      FIX_TILE   <= '0;
      FIX_PAL    <= '0;
      TILE_VALID <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      PCK2B_EN   <= 1'b0;
      TILE_VALID <= 1'b0;
      if (LINE_START && state != IDLE) begin
        // Abort: acks are only taken in WAIT, so a late ack for the dropped
        // request lands while RD is low and is never consumed.
        VRAM_RD <= 1'b0;
        col     <= '0;
        row     <= VCOUNT[7:3];
        is_sync <= 1'b0;
        if (FIX_EN) begin
          state <= (VCOUNT == FIRST_LINE) ? SYNC_REQ : REQ;
        end else begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: if (LINE_START && FIX_EN) begin
            row   <= VCOUNT[7:3];
            col   <= '0;
            BUSY  <= 1'b1;
            state <= (VCOUNT == FIRST_LINE) ? SYNC_REQ : REQ;
          end
          SYNC_REQ: begin
            VRAM_ADDR <= sync_addr;
            VRAM_RD   <= 1'b1;
            is_sync   <= 1'b1;
            state     <= WAIT;
          end
          REQ: begin
            VRAM_ADDR <= entry_addr;
            VRAM_RD   <= 1'b1;
            is_sync   <= 1'b0;
            state     <= WAIT;
          end
          WAIT: if (VRAM_ACK) begin
            VRAM_RD <= 1'b0;
            ADDR    <= VRAM_ADDR[10:0];
            PBUS    <= VRAM_DATA[14:0];
            data_q  <= VRAM_DATA;
            state   <= STB1;
          end
          STB1: if (CLK_EN) begin
            PCK2B_EN <= 1'b1;
            state    <= STB2;
          end
          STB2: if (CLK_EN) begin
            PCK2B_EN <= 1'b1;
            if (!is_sync) begin
              FIX_TILE   <= data_q[11:0];
              FIX_PAL    <= data_q[15:12];
              TILE_VALID <= 1'b1;
            end
            state <= NEXT;
          end
          NEXT: begin
            if (!FIX_EN || (!is_sync && col == LAST_COL)) begin
              state <= IDLE;
              BUSY  <= 1'b0;
              col   <= '0;
            end else begin
              // The sync word does not consume a column.
              if (!is_sync) col <= col + 6'd1;
              state <= REQ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neo_fix_fetch.sv
// Directed bench for neo_fix_fetch: table of full-line fetches plus hand
// sequences for reset, abort, enable drop and mid-fetch reset.
module tb_neo_fix_fetch;

  logic        CLK, nRESET, CLK_EN, FIX_EN, LINE_START;
  logic [8:0]  VCOUNT;
  logic [15:0] VRAM_ADDR;
  logic        VRAM_RD, VRAM_ACK;
  logic [15:0] VRAM_DATA;
  logic [10:0] ADDR;
  logic [14:0] PBUS;
  logic        PCK2B_EN;
  logic [11:0] FIX_TILE;
  logic [3:0]  FIX_PAL;
  logic        TILE_VALID, BUSY;

  neo_fix_fetch dut (
    .CLK(CLK), .nRESET(nRESET), .CLK_EN(CLK_EN), .FIX_EN(FIX_EN),
    .LINE_START(LINE_START), .VCOUNT(VCOUNT), .VRAM_ADDR(VRAM_ADDR),
    .VRAM_RD(VRAM_RD), .VRAM_ACK(VRAM_ACK), .VRAM_DATA(VRAM_DATA),
    .ADDR(ADDR), .PBUS(PBUS), .PCK2B_EN(PCK2B_EN), .FIX_TILE(FIX_TILE),
    .FIX_PAL(FIX_PAL), .TILE_VALID(TILE_VALID), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [8:0]  vc;
    int          dly;
    bit          slow;
    bit          ovr;
    logic [15:0] oa, od;
    int          reads;
    logic [14:0] fpbus;
    logic [11:0] ftile;
    logic [3:0]  fpal;
    logic [10:0] laddr;
    logic [14:0] lpbus;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  int idx, reads, tvs, strobes_e, wcnt, cyc = 0;
  int e_addr, e_stab, e_stb, e_tv;
  bit rd_prev = 0, esync, hold_ack = 0, slow = 0, ovr_on = 0, got_stb, got_tv;
  int ack_dly = 2;
  logic [4:0]  erow;
  logic [15:0] cur_addr = '0, ovr_addr = '0, ovr_data = '0;
  logic [14:0] first_pbus;
  logic [11:0] first_tile;
  logic [3:0]  first_pal;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] model_data(input logic [15:0] a);
    return (ovr_on && a == ovr_addr) ? ovr_data : (a ^ 16'hFFFF);
  endfunction

  function automatic logic [15:0] exp_addr(input int i);
    int c;
    if (esync && i == 0) return 16'h77E2;
    c = esync ? i - 1 : i;
    return 16'h7000 | 16'(c << 5) | {11'd0, erow};
  endfunction

  // One clock: observe settled outputs at the falling edge, then act as VRAM.
  task automatic tick();
    logic [15:0] d;
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
    if (PCK2B_EN) begin
      strobes_e++;
      if (!CLK_EN || VRAM_RD || ADDR != cur_addr[10:0]) e_stb++;
      if (!got_stb) begin first_pbus = PBUS; got_stb = 1; end
    end
    if (TILE_VALID) begin
      tvs++;
      d = model_data(cur_addr);
      if (FIX_TILE != d[11:0] || FIX_PAL != d[15:12]) e_tv++;
      if (!got_tv) begin first_tile = FIX_TILE; first_pal = FIX_PAL; got_tv = 1; end
    end
    if (VRAM_RD) begin
      if (!rd_prev) begin
        if (idx > 0 && strobes_e != 2) e_stb++;
        strobes_e = 0;
        if (VRAM_ADDR != exp_addr(idx)) e_addr++;
        cur_addr = VRAM_ADDR;
        idx++; reads++; wcnt = 0;
      end else begin
        if (VRAM_ADDR != cur_addr) e_stab++;
        wcnt++;
      end
    end
    rd_prev = VRAM_RD;
    VRAM_ACK = 1'b0;
    if (VRAM_RD && !hold_ack && wcnt >= ack_dly) begin
      VRAM_ACK  = 1'b1;
      VRAM_DATA = model_data(cur_addr);
    end
    CLK_EN     = slow ? (cyc % 3 == 0) : 1'b1;
    LINE_START = 1'b0;
  endtask

  task automatic start_line(input logic [8:0] vc);
    VCOUNT = vc; LINE_START = 1'b1;
    erow = vc[7:3]; esync = (vc == 9'd16);
    idx = 0; reads = 0; tvs = 0; strobes_e = 0;
    e_addr = 0; e_stab = 0; e_stb = 0; e_tv = 0;
    got_stb = 0; got_tv = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin tick(); n++; end while (BUSY && n < budget);
    check({name, "_timeout"}, 64'(BUSY), 64'd0);
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{9'd40,  2,  0, 1, 16'h7005, 16'hA5FF, 40, 15'h25FF, 12'h5FF, 4'hA, 11'h4E5, 15'h0B1A};
    tbl[1] = '{9'd16,  2,  0, 1, 16'h77E2, 16'h0123, 41, 15'h0123, 12'hFFD, 4'h8, 11'h4E2, 15'h0B1D};
    tbl[2] = '{9'd8,   10, 1, 0, 16'h0000, 16'h0000, 40, 15'h0FFE, 12'hFFE, 4'h8, 11'h4E1, 15'h0B1E};
    tbl[3] = '{9'd255, 0,  1, 0, 16'h0000, 16'h0000, 40, 15'h0FE0, 12'hFE0, 4'h8, 11'h4FF, 15'h0B00};

    nRESET = 0; CLK_EN = 1; FIX_EN = 1; LINE_START = 0; VCOUNT = '0;
    VRAM_ACK = 0; VRAM_DATA = '0;
    start_line(9'd0); LINE_START = 1'b0;
    repeat (4) tick();
    check("reset_outputs",
          {2'b0, VRAM_ADDR, VRAM_RD, ADDR, PBUS, PCK2B_EN, FIX_TILE, FIX_PAL, TILE_VALID, BUSY}, 64'd0);
    nRESET = 1;
    tick();

    for (int i = 0; i < 4; i++) begin
      ack_dly = tbl[i].dly; slow = tbl[i].slow;
      ovr_on = tbl[i].ovr; ovr_addr = tbl[i].oa; ovr_data = tbl[i].od;
      start_line(tbl[i].vc);
      wait_idle($sformatf("row%0d", i), 5000);
      check($sformatf("row%0d_reads", i), 64'(reads), 64'(tbl[i].reads));
      check($sformatf("row%0d_addr_seq_errs", i), 64'(e_addr), 64'd0);
      check($sformatf("row%0d_rd_stable_errs", i), 64'(e_stab), 64'd0);
      check($sformatf("row%0d_strobe_errs", i), 64'(e_stb), 64'd0);
      check($sformatf("row%0d_last_strobes", i), 64'(strobes_e), 64'd2);
      check($sformatf("row%0d_tile_valids", i), 64'(tvs), 64'd40);
      check($sformatf("row%0d_tile_data_errs", i), 64'(e_tv), 64'd0);
      check($sformatf("row%0d_first_pbus", i), 64'(first_pbus), 64'(tbl[i].fpbus));
      check($sformatf("row%0d_first_tile", i), 64'({first_pal, first_tile}),
            64'({tbl[i].fpal, tbl[i].ftile}));
      tick(); tick();
      check($sformatf("row%0d_hold_addr_pbus", i), 64'({ADDR, PBUS}),
            64'({tbl[i].laddr, tbl[i].lpbus}));
      check($sformatf("row%0d_rd_idle", i), 64'(VRAM_RD), 64'd0);
    end
    ovr_on = 0; slow = 0; ack_dly = 2;

    // Abort at column 7 with a late ack for the dropped read.
    start_line(9'd40);
    for (int n = 0; n < 2000 && reads < 8; n++) tick();
    hold_ack = 1;
    repeat (3) tick();
    check("abort_tv_before", 64'(tvs), 64'd7);
    check("abort_rd_held", 64'({VRAM_RD, VRAM_ADDR}), 64'({1'b1, 16'h70E5}));
    start_line(9'd48);
    tick();
    check("abort_rd_dropped", 64'(VRAM_RD), 64'd0);
    VRAM_ACK = 1'b1; VRAM_DATA = 16'hDEAD;
    hold_ack = 0;
    wait_idle("abort", 5000);
    check("abort_reads", 64'(reads), 64'd40);
    check("abort_addr_seq_errs", 64'(e_addr), 64'd0);
    check("abort_tile_valids", 64'(tvs), 64'd40);
    check("abort_tile_data_errs", 64'(e_tv), 64'd0);

    // FIX_EN falls during the third entry: that entry completes, then idle.
    start_line(9'd40);
    for (int n = 0; n < 2000 && reads < 3; n++) tick();
    FIX_EN = 0;
    wait_idle("fixen", 500);
    check("fixen_reads", 64'(reads), 64'd3);
    check("fixen_tile_valids", 64'(tvs), 64'd3);
    check("fixen_last_strobes", 64'(strobes_e), 64'd2);

    // LINE_START with the layer disabled stays idle.
    start_line(9'd40);
    repeat (3) tick();
    check("disabled_idle", 64'({BUSY, VRAM_RD}), 64'd0);
    check("disabled_reads", 64'(reads), 64'd0);
    FIX_EN = 1;

    // Reset mid-fetch.
    start_line(9'd40);
    repeat (12) tick();
    check("midreset_busy_before", 64'(BUSY), 64'd1);
    nRESET = 0;
    tick();
    check("midreset_outputs",
          {2'b0, VRAM_ADDR, VRAM_RD, ADDR, PBUS, PCK2B_EN, FIX_TILE, FIX_PAL, TILE_VALID, BUSY}, 64'd0);
    nRESET = 1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
